// File: rtl/tdm_pkg.sv
// Shared definitions for the TDM receive demultiplexer.
// Latency: none (types and constants only).
// Backpressure: none. Build option TDM_DEMUX_PARITY_EN adds a parity slot per frame.
package tdm_pkg;

   // Receiver framing state: waiting for a sync, or tracking slots of a frame
   typedef enum logic {
      HUNT   = 1'b0,
      ACTIVE = 1'b1
   } state_t;

   localparam int NUM_CH_DEF = 8;
   localparam int SLOT_W_DEF = 4;

   // Index of the final slot in a frame; the parity slot follows the data slots
   function automatic int last_slot(input int num_ch);
`ifdef TDM_DEMUX_PARITY_EN
      return num_ch;
`else
      return num_ch - 1;
`endif
   endfunction

   localparam int LAST_SLOT = last_slot(NUM_CH_DEF);

endpackage

// File: rtl/tdm_demux_8ch_if.sv
// Serial TDM input and parallel frame output bundle for tdm_demux_8ch.
// Latency: none (wiring only).
// Backpressure: none; the link is free-running, din_valid qualifies each slot bit.
interface tdm_demux_8ch_if #(
   parameter int NUM_CH = 8,
   parameter int SLOT_W = 4
);
   logic              din;
   logic              din_valid;
   logic              frame_sync;
   logic [NUM_CH-1:0] dout;
   logic              frame_done;
   logic              sync_err;
   logic              locked;
   logic [SLOT_W-1:0] slot;
   logic              parity_err;

   // Link side: drives the serial stream, observes frames and status
   modport master (
      output din, din_valid, frame_sync,
      input  dout, frame_done, sync_err, locked, slot, parity_err
   );

   // Demultiplexer side
   modport slave (
      input  din, din_valid, frame_sync,
      output dout, frame_done, sync_err, locked, slot, parity_err
   );
endinterface

// File: rtl/tdm_slot_counter.sv
// Slot index counter: increment with wrap at LAST, load-to-1 on a frame start, clear.
// Latency: new slot value visible one cycle after the command.
// Backpressure: none; holds when no command is given.
module tdm_slot_counter #(
   parameter int SLOT_W = 4,
   parameter int LAST   = 7
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              inc,
   input  logic              load_one,
   input  logic              clr,
   output logic [SLOT_W-1:0] slot,
   output logic              at_last
);
   logic [SLOT_W-1:0] slot_q, slot_d;

   // Next slot: clear beats load, load beats increment; increment wraps after LAST
   always_comb begin
      slot_d = slot_q;
      if (clr) begin
         slot_d = '0;
      end else if (load_one) begin
         slot_d = SLOT_W'(1);
      end else if (inc) begin
         slot_d = at_last ? '0 : slot_q + SLOT_W'(1);
      end
   end

   // Slot register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) slot_q <= '0;
      else     slot_q <= slot_d;
   end

   assign slot    = slot_q;
   assign at_last = (slot_q == SLOT_W'(LAST));
endmodule

// File: rtl/tdm_demux_8ch.sv
// TDM demultiplexer: serial slot bits collected into a shadow word, published as a frame.
// Latency: dout/frame_done one cycle after the last slot bit is accepted.
// Backpressure: none; cycles with din_valid low stall the frame. Option: TDM_DEMUX_PARITY_EN.
module tdm_demux_8ch
   import tdm_pkg::*;
#(
   parameter int NUM_CH = NUM_CH_DEF,
   parameter int SLOT_W = SLOT_W_DEF
) (
   input  logic           clk,
   input  logic           rst,
   tdm_demux_8ch_if.slave bus
);
   localparam int LAST = last_slot(NUM_CH);

   state_t            state_q, state_d;
   logic [NUM_CH-1:0] shadow_q, shadow_d;
   logic [NUM_CH-1:0] dout_q, dout_d;
   logic              frame_done_q, frame_done_d;
   logic              sync_err_q, sync_err_d;
   logic              parity_err_q, parity_err_d;

   logic              cnt_inc, cnt_load_one, cnt_clr;
   logic [SLOT_W-1:0] slot;
   logic              at_last;

   tdm_slot_counter #(
      .SLOT_W (SLOT_W),
      .LAST   (LAST)
   ) u_slot_counter (
      .clk      (clk),
      .rst      (rst),
      .inc      (cnt_inc),
      .load_one (cnt_load_one),
      .clr      (cnt_clr),
      .slot     (slot),
      .at_last  (at_last)
   );

   // Framing FSM, slot routing into the shadow word and frame publication
   always_comb begin
      state_d      = state_q;
      shadow_d     = shadow_q;
      dout_d       = dout_q;
      frame_done_d = 1'b0;
      sync_err_d   = 1'b0;
      parity_err_d = 1'b0;
      cnt_inc      = 1'b0;
      cnt_load_one = 1'b0;
      cnt_clr      = 1'b0;

      if (bus.din_valid) begin
         case (state_q)
            HUNT: begin
               // Bits before the first sync are dropped silently
               if (bus.frame_sync) begin
                  shadow_d     = '0;
                  shadow_d[0]  = bus.din;
                  cnt_load_one = 1'b1;
                  state_d      = ACTIVE;
               end
            end
            default: begin
               if (bus.frame_sync) begin
                  // A sync anywhere but slot 0 abandons the partial frame and restarts
                  sync_err_d   = (slot != '0);
                  shadow_d     = '0;
                  shadow_d[0]  = bus.din;
                  cnt_load_one = 1'b1;
               end else if (slot == '0) begin
                  // Expected sync never came: lose lock and hunt again
                  sync_err_d = 1'b1;
                  state_d    = HUNT;
                  cnt_clr    = 1'b1;
               end else if (at_last) begin
                  cnt_clr = 1'b1;
`ifdef TDM_DEMUX_PARITY_EN
                  // Even parity over data plus parity bit must be zero
                  if ((^shadow_q) ^ bus.din) begin
                     parity_err_d = 1'b1;
                  end else begin
                     dout_d       = shadow_q;
                     frame_done_d = 1'b1;
                  end
`else
                  dout_d       = {bus.din, shadow_q[NUM_CH-2:0]};
                  frame_done_d = 1'b1;
`endif
               end else begin
                  for (int k = 0; k < NUM_CH; k++) begin
                     if (slot == SLOT_W'(k)) shadow_d[k] = bus.din;
                  end
                  cnt_inc = 1'b1;
               end
            end
         endcase
      end
   end

   // State, shadow word, published frame and status pulses
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= HUNT;
         shadow_q     <= '0;
         dout_q       <= '0;
         frame_done_q <= 1'b0;
         sync_err_q   <= 1'b0;
         parity_err_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         shadow_q     <= shadow_d;
         dout_q       <= dout_d;
         frame_done_q <= frame_done_d;
         sync_err_q   <= sync_err_d;
         parity_err_q <= parity_err_d;
      end
   end

   assign bus.dout       = dout_q;
   assign bus.frame_done = frame_done_q;
   assign bus.sync_err   = sync_err_q;
   assign bus.parity_err = parity_err_q;
   assign bus.locked     = (state_q == ACTIVE);
   assign bus.slot       = slot;
endmodule
